// File: rtl/mprj_io_pkg.sv
// Shared types and constants for the user-project GPIO configuration loader.
package mprj_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } xfer_state_e;

  localparam int DEF_TOTAL_PADS = 38;
  localparam int DEF_AREA1PADS  = 19;
  localparam int DEF_CFG_BITS   = 13;

  // Bits shifted per transfer: both chains run for the length of the longer one.
  function automatic int shift_len(input int total_pads, input int area1pads,
                                   input int cfg_bits);
    int n1;
    int n2;
    n1 = area1pads;
    n2 = total_pads - area1pads;
    return ((n1 > n2) ? n1 : n2) * cfg_bits;
  endfunction

endpackage

// File: rtl/mprj_cfg_tick.sv
// Serial-clock phase generator: one bit slot is 2*CLK_DIV system clocks,
// low for the first half and high for the second.
module mprj_cfg_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic rise,
  output logic bit_end,
  output logic sclk_level
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam logic [PW-1:0] RISE_PH = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] HIGH_PH = PW'(CLK_DIV);
  localparam logic [PW-1:0] LAST_PH = PW'(2 * CLK_DIV - 1);

  logic [PW-1:0] phase;

  // Phase counter: held at zero while idle so every transfer starts on a fresh slot.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset || !run) begin
      phase <= '0;
    end else if (phase == LAST_PH) begin
      phase <= '0;
    end else begin
      phase <= phase + PW'(1);
    end
  end

  assign rise       = (phase == RISE_PH);
  assign bit_end    = (phase == LAST_PH);
  assign sclk_level = (phase >= HIGH_PH);

endmodule

// File: rtl/mprj_io_cfg_loader.sv
// Snapshots one configuration word per GPIO pad and shifts the words out on two
// parallel daisy chains (area 1 and area 2), then strobes the pad latches.
module mprj_io_cfg_loader
  import mprj_io_pkg::*;
#(
  parameter int TOTAL_PADS = DEF_TOTAL_PADS,
  parameter int AREA1PADS  = DEF_AREA1PADS,
  parameter int CFG_BITS   = DEF_CFG_BITS,
  parameter int CLK_DIV    = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           xfer_start,
  input  logic [TOTAL_PADS*CFG_BITS-1:0] cfg_word,
  output logic                           busy,
  output logic                           done,
  output logic                           serial_clock,
  output logic                           serial_load,
  output logic                           serial_data_1,
  output logic                           serial_data_2
);

  localparam int N1 = AREA1PADS;
  localparam int N2 = TOTAL_PADS - AREA1PADS;
  localparam int L  = shift_len(TOTAL_PADS, AREA1PADS, CFG_BITS);
  localparam int BW = (L > 1) ? $clog2(L) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(L - 1);

  xfer_state_e   state;
  logic [BW-1:0] bit_cnt;
  logic [L-1:0]  snap1;
  logic [L-1:0]  snap2;
  logic [L-1:0]  sr1;
  logic [L-1:0]  sr2;
  logic          run;
  logic          rise;
  logic          bit_end;
  logic          sclk_level;

  assign run = (state != IDLE);

  mprj_cfg_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .rise       (rise),
    .bit_end    (bit_end),
    .sclk_level (sclk_level)
  );

  // Arrange pad words in shift order, MSB of the vector goes out first; the
  // upper (first-shifted) bits stay zero so the shorter chain is front-padded.
  always_comb begin
    // NOTE: defaults first so every path assigns every bit and no latch is inferred.
    snap1 = '0;
    snap2 = '0;
    // Chain 1 sends pad N1-1 first down to pad 0: natural vector order.
    snap1[N1*CFG_BITS-1:0] = cfg_word[N1*CFG_BITS-1:0];
    // Chain 2 sends pad AREA1PADS first up to TOTAL_PADS-1: word order reversed.
    for (int i = 0; i < N2; i++) begin
      snap2[(N2-1-i)*CFG_BITS +: CFG_BITS] = cfg_word[(AREA1PADS+i)*CFG_BITS +: CFG_BITS];
    end
  end

  // Transfer FSM with bit counter, shift registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: sr1/sr2 are pure datapath, fully reloaded on every accepted start,
      // so they are deliberately left out of reset.
      state         <= IDLE;
      bit_cnt       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      serial_clock  <= 1'b0;
      serial_load   <= 1'b0;
      serial_data_1 <= 1'b0;
      serial_data_2 <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer_start) begin
            state         <= SHIFT;
            busy          <= 1'b1;
            bit_cnt       <= '0;
            serial_data_1 <= snap1[L-1];
            serial_data_2 <= snap2[L-1];
            sr1           <= snap1 << 1;
            sr2           <= snap2 << 1;
          end
        end
        SHIFT: begin
          // Next-cycle clock level: high from mid-slot through the slot end.
          serial_clock <= rise | (sclk_level & ~bit_end);
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
              state         <= LOAD;
              serial_load   <= 1'b1;
              serial_data_1 <= 1'b0;
              serial_data_2 <= 1'b0;
            end else begin
              bit_cnt       <= bit_cnt + BW'(1);
              serial_data_1 <= sr1[L-1];
              serial_data_2 <= sr2[L-1];
              sr1           <= sr1 << 1;
              sr2           <= sr2 << 1;
            end
          end
        end
        LOAD: begin
          if (rise) begin
            state       <= IDLE;
            serial_load <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
